bf_io_port: RTL and testbench
=============================

Name: bf_io_port

Overview:
- Parametrised I/O peripheral for the bfcpu io_* port (req/dir/wdata/ack/rdata), replacing the single LED register in the board top.
- Write (`.`) pushes a byte into a TX FIFO that drains to an external sink over valid/ready; read (`,`) pops from an RX FIFO filled by an external source.
- Keeps an active-low LED mirror of the last written byte.
- Stalls the CPU by withholding io_ack when the TX FIFO is full, or when the RX FIFO is empty and blocking mode is selected.

Parameters:
- DATA_W, 8, width of io_wdata/io_rdata/tx_data/rx_data.
- DEPTH, 16, entries per FIFO; power of two, >= 2.
- LED_W, 3, LED mirror width; LED_W <= DATA_W.
- READ_BLOCK, 1, 1 = read of empty RX waits; 0 = read of empty RX completes at once with EOF_VAL.
- EOF_VAL, 0, value returned for a non-blocking read of empty RX.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- io_req  in  1  CPU request, held until io_ack is seen.
- io_dir  in  1  DIRECTION_WRITE / DIRECTION_READ (shared direction constants).
- io_wdata  in  DATA_W  write byte.
- io_ack  out  1  one-cycle completion pulse.
- io_rdata  out  DATA_W  read result; valid with io_ack; held until the next read completes.
- tx_valid  out  1  TX FIFO non-empty.
- tx_data  out  DATA_W  TX FIFO head.
- tx_ready  in  1  sink accepts head when tx_valid && tx_ready.
- rx_valid  in  1  source offers rx_data.
- rx_data  in  DATA_W  source byte.
- rx_ready  out  1  RX FIFO not full.
- led_n  out  LED_W  ~(last written byte)[LED_W-1:0].
- tx_level  out  clog2(DEPTH)+1  TX occupancy.
- rx_level  out  clog2(DEPTH)+1  RX occupancy.

Behaviour:
- Reset values while rst = 1:
  - io_ack 0, io_rdata 0, led_n all ones.
  - Both FIFOs empty, so tx_valid 0, rx_ready 1, levels 0.
  - FSM in IDLE.
  - Any in-flight transaction is discarded. If io_req is still high after reset, it is a new transaction.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE: when io_req = 1, latch io_dir and io_wdata, then evaluate in the same cycle:
  - Write with TX not full: push, update led_n, go to ACK.
  - Write with TX full: go to WAIT.
  - Read with RX not empty: pop, register head into io_rdata, go to ACK.
  - Read with RX empty and READ_BLOCK = 1: go to WAIT.
  - Read with RX empty and READ_BLOCK = 0: io_rdata <= EOF_VAL, go to ACK.
- WAIT: re-evaluate each cycle against the latched dir/wdata. When the condition clears, perform the same push/pop and go to ACK. io_req is not re-sampled in WAIT.
- ACK: io_ack = 1 for exactly this one cycle, then go to HOLD.
- HOLD: io_ack = 0 and io_req is ignored for this one cycle, so the CPU can drop req. Then go to IDLE.
- Minimum latency: req sampled in cycle N, io_ack high in cycle N+1, next req accepted in cycle N+3.
- Full and empty flags are the registered FIFO state. A same-cycle sink pop does not unblock a CPU write in that cycle, and a same-cycle source push does not satisfy a CPU read in that cycle. No fall-through.
- Simultaneous push and pop on one FIFO:
  - Not full and not empty: both happen, level unchanged.
  - Full: only the pop occurs, and the CPU push retries next cycle.
  - Empty: only the push occurs.
- Pointers wrap modulo DEPTH.
- Level = wptr - rptr, using clog2(DEPTH)+1-bit pointers. Full when level == DEPTH; empty when level == 0.
- io_rdata changes only on read completion. Writes never alter it.
- led_n is updated only on a completed write.

Decomposition:
- Shared package/header holds:
  - DIRECTION_WRITE / DIRECTION_READ (existing direction macros).
  - FSM state encoding: IDLE = 0, WAIT = 1, ACK = 2, HOLD = 3.
- Sub-module bf_io_fifo:
  - Parameters DATA_W and DEPTH.
  - push/din, pop/dout (head, combinational), full, empty, level.
  - Synchronous active-high rst.
  - Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset then write: write 0x05 with tx_ready = 0 -> io_ack pulses 1 cycle after req, led_n = 3'b010, tx_valid = 1, tx_data = 0x05, tx_level = 1.
- TX full stall: 16 writes with tx_ready = 0, then a 17th write 0xAA -> no ack. Raise tx_ready for 1 cycle -> ack 2 cycles after the pop. 0xAA is the last byte drained; tx_level returns to 16 after the retry push.
- Blocking read: READ_BLOCK = 1, RX empty, read -> io_ack stays 0 for 10 cycles. Drive rx_valid with 0x3C -> io_ack within 2 cycles, io_rdata = 0x3C, rx_level = 0.
- Non-blocking read: READ_BLOCK = 0, RX empty, read -> ack 1 cycle after req, io_rdata = EOF_VAL = 0x00.
- Back-to-back handshake: io_req held high across ack -> exactly one push per req-high period separated by HOLD. Verify the 3-cycle req-to-next-accept spacing and single-cycle io_ack.
- Reset mid-WAIT: TX full and write pending, assert rst 1 cycle -> io_ack 0, tx_level 0, led_n = 3'b111. A still-high io_req afterwards completes as a new write.

Source files
------------

// File: rtl/bf_io_pkg.sv
// bf_io_pkg: direction constants and FSM state encoding shared by the bfcpu I/O port.
package bf_io_pkg;
   localparam logic DIRECTION_WRITE = 1'b1;
   localparam logic DIRECTION_READ  = 1'b0;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_HOLD = 2'd3
   } state_t;
endpackage

// File: rtl/bf_io_fifo.sv
// bf_io_fifo: synchronous FIFO with registered flags; push when full and pop when empty are ignored.
module bf_io_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        din,
   input  logic                     pop,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0] r_wptr, r_rptr;
   logic w_push, w_pop;
   assign level  = r_wptr - r_rptr;
   assign full   = level == LVL_FULL;
   assign empty  = level == '0;
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign dout   = r_mem[r_rptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/bf_io_port.sv
// bf_io_port: bfcpu io_* peripheral with TX/RX FIFOs, an active-low LED mirror and a
// req/ack handshake that stalls the CPU on TX full or (optionally) RX empty.
module bf_io_port
   import bf_io_pkg::*;
#(
   parameter int              DATA_W     = 8,
   parameter int              DEPTH      = 16,
   parameter int              LED_W      = 3,
   parameter bit              READ_BLOCK = 1'b1,
   parameter logic [DATA_W-1:0] EOF_VAL  = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   io_req,
   input  logic                   io_dir,
   input  logic [DATA_W-1:0]      io_wdata,
   output logic                   io_ack,
   output logic [DATA_W-1:0]      io_rdata,
   output logic                   tx_valid,
   output logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_ready,
   input  logic                   rx_valid,
   input  logic [DATA_W-1:0]      rx_data,
   output logic                   rx_ready,
   output logic [LED_W-1:0]       led_n,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic [$clog2(DEPTH):0] rx_level
);
   state_t r_state, w_next;
   logic r_dir;
   logic [DATA_W-1:0] r_wdata, r_rdata, w_wdata, w_rx_head;
   logic [LED_W-1:0] r_led_n;
   logic w_dir, w_active, w_tx_push, w_rx_pop, w_eof, w_done;
   logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   always_ff @(posedge clk) begin
      r_state <= rst ? S_IDLE : w_next;
   end
   always_comb begin
      w_next = (r_state == S_IDLE) ? (!io_req ? S_IDLE : w_done ? S_ACK : S_WAIT) :
               (r_state == S_WAIT) ? (w_done ? S_ACK : S_WAIT) :
               (r_state == S_ACK)  ? S_HOLD : S_IDLE;
   end
   // In IDLE the request is evaluated straight off the bus; WAIT uses the latched copy.
   always_comb begin
      w_dir     = (r_state == S_IDLE) ? io_dir : r_dir;
      w_wdata   = (r_state == S_IDLE) ? io_wdata : r_wdata;
      w_active  = (r_state == S_IDLE && io_req) || r_state == S_WAIT;
      w_tx_push = w_active && w_dir == DIRECTION_WRITE && !w_tx_full;
      w_rx_pop  = w_active && w_dir == DIRECTION_READ && !w_rx_empty;
      w_eof     = w_active && w_dir == DIRECTION_READ && w_rx_empty && !READ_BLOCK;
      w_done    = w_tx_push || w_rx_pop || w_eof;
      io_ack    = r_state == S_ACK;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dir   <= DIRECTION_WRITE;
         r_wdata <= '0;
         r_rdata <= '0;
         r_led_n <= '1;
      end else begin
         if (r_state == S_IDLE && io_req) begin
            r_dir   <= io_dir;
            r_wdata <= io_wdata;
         end
         if (w_rx_pop) r_rdata <= w_rx_head;
         else if (w_eof) r_rdata <= EOF_VAL;
         if (w_tx_push) r_led_n <= ~w_wdata[LED_W-1:0];
      end
   end
   bf_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
      .clk(clk), .rst(rst), .push(w_tx_push), .din(w_wdata), .pop(tx_ready),
      .dout(tx_data), .full(w_tx_full), .empty(w_tx_empty), .level(tx_level)
   );
   bf_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
      .clk(clk), .rst(rst), .push(rx_valid), .din(rx_data), .pop(w_rx_pop),
      .dout(w_rx_head), .full(w_rx_full), .empty(w_rx_empty), .level(rx_level)
   );
   assign tx_valid = !w_tx_empty;
   assign rx_ready = !w_rx_full;
   assign io_rdata = r_rdata;
   assign led_n    = r_led_n;
endmodule

// File: tb/tb_bf_io_port.sv
// tb_bf_io_port: directed scenarios plus a randomized run scored against queue-based FIFO models.
module tb_bf_io_port;
   import bf_io_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   logic io_req = 1'b0, io_dir = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
   logic [7:0] io_wdata = '0, rx_data = '0;
   logic io_ack, tx_valid, rx_ready;
   logic [7:0] io_rdata, tx_data;
   logic [2:0] led_n;
   logic [4:0] tx_level, rx_level;
   logic nb_req = 1'b0, nb_dir = 1'b0, nb_tx_ready = 1'b0, nb_rx_valid = 1'b0;
   logic [7:0] nb_wdata = '0, nb_rx_data = '0;
   logic nb_ack, nb_tx_valid, nb_rx_ready;
   logic [7:0] nb_rdata, nb_tx_data;
   logic [2:0] nb_led_n;
   logic [4:0] nb_tx_level, nb_rx_level;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   bf_io_port #(.DATA_W(8), .DEPTH(16), .LED_W(3), .READ_BLOCK(1'b1), .EOF_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .io_req(io_req), .io_dir(io_dir), .io_wdata(io_wdata),
      .io_ack(io_ack), .io_rdata(io_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .led_n(led_n), .tx_level(tx_level), .rx_level(rx_level)
   );
   bf_io_port #(.DATA_W(8), .DEPTH(16), .LED_W(3), .READ_BLOCK(1'b0), .EOF_VAL(8'h00)) dut_nb (
      .clk(clk), .rst(rst), .io_req(nb_req), .io_dir(nb_dir), .io_wdata(nb_wdata),
      .io_ack(nb_ack), .io_rdata(nb_rdata), .tx_valid(nb_tx_valid), .tx_data(nb_tx_data),
      .tx_ready(nb_tx_ready), .rx_valid(nb_rx_valid), .rx_data(nb_rx_data), .rx_ready(nb_rx_ready),
      .led_n(nb_led_n), .tx_level(nb_tx_level), .rx_level(nb_rx_level)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; io_req = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; nb_req = 1'b0; nb_rx_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Issue one request from IDLE, return cycles to io_ack (-1 on timeout), and leave the DUT in IDLE.
   task automatic xfer(input logic dir, input logic [7:0] d, output int lat);
      io_req = 1'b1; io_dir = dir; io_wdata = d; lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (io_ack) begin lat = i; break; end
      end
      io_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", io_ack); end
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", io_rdata); end
      checks++; if (led_n !== 3'b111) begin errors++; $display("FAIL reset_led: got %b want 111", led_n); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
      checks++; if (tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL reset_levels: got %0d/%0d want 0/0", tx_level, rx_level); end
      rst = 1'b0;
   endtask

   task automatic test_write();
      do_reset();
      io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h05;
      @(negedge clk);
      checks++; if (io_ack !== 1'b1) begin errors++; $display("FAIL write_ack_latency: got %b want 1", io_ack); end
      checks++; if (led_n !== 3'b010) begin errors++; $display("FAIL write_led: got %b want 010", led_n); end
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h05) begin errors++; $display("FAIL write_tx_head: got %b/%h want 1/05", tx_valid, tx_data); end
      checks++; if (tx_level !== 5'd1) begin errors++; $display("FAIL write_tx_level: got %0d want 1", tx_level); end
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL write_rdata_kept: got %h want 00", io_rdata); end
      io_req = 1'b0;
      @(negedge clk);
      checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL write_ack_width: got %b want 0", io_ack); end
      @(negedge clk);
   endtask

   task automatic test_tx_full();
      int lat, bad, acks;
      logic [7:0] exp;
      do_reset();
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         xfer(DIRECTION_WRITE, 8'(i), lat);
         if (lat != 1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL fill_latency: got %0d slow writes want 0", bad); end
      checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL fill_level: got %0d want 16", tx_level); end
      io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'hAA;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (io_ack) acks++;
      end
      checks++; if (acks != 0) begin errors++; $display("FAIL full_stall: got %0d acks want 0", acks); end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL full_no_fallthrough: got %b want 0", io_ack); end
      @(negedge clk);
      checks++; if (io_ack !== 1'b1) begin errors++; $display("FAIL full_retry_ack: got %b want 1", io_ack); end
      checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL full_retry_level: got %0d want 16", tx_level); end
      checks++; if (led_n !== 3'b101) begin errors++; $display("FAIL full_retry_led: got %b want 101", led_n); end
      io_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tx_ready = 1'b1;
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         exp = (k < 15) ? 8'(k + 1) : 8'hAA;
         if (tx_valid !== 1'b1 || tx_data !== exp) bad++;
         @(negedge clk);
      end
      tx_ready = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL drain_order: got %0d wrong bytes want 0", bad); end
      checks++; if (tx_valid !== 1'b0 || tx_level !== 5'd0) begin errors++; $display("FAIL drain_empty: got %b/%0d want 0/0", tx_valid, tx_level); end
   endtask

   task automatic test_blocking_read();
      int acks, lat;
      do_reset();
      io_req = 1'b1; io_dir = DIRECTION_READ;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (io_ack) acks++;
      end
      checks++; if (acks != 0) begin errors++; $display("FAIL block_stall: got %0d acks want 0", acks); end
      rx_valid = 1'b1; rx_data = 8'h3C; lat = -1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
         if (io_ack) begin
            lat = i;
            checks++; if (io_rdata !== 8'h3C) begin errors++; $display("FAIL block_rdata: got %h want 3c", io_rdata); end
            checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL block_rx_level: got %0d want 0", rx_level); end
            break;
         end
      end
      checks++; if (lat != 2) begin errors++; $display("FAIL block_wake_latency: got %0d want 2", lat); end
      io_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_nonblocking_read();
      do_reset();
      nb_rx_valid = 1'b1; nb_rx_data = 8'h77;
      @(negedge clk);
      nb_rx_valid = 1'b0;
      nb_req = 1'b1; nb_dir = DIRECTION_READ;
      @(negedge clk);
      checks++; if (nb_ack !== 1'b1 || nb_rdata !== 8'h77) begin errors++; $display("FAIL nb_data_read: got %b/%h want 1/77", nb_ack, nb_rdata); end
      nb_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nb_req = 1'b1;
      @(negedge clk);
      checks++; if (nb_ack !== 1'b1) begin errors++; $display("FAIL nb_eof_ack: got %b want 1", nb_ack); end
      checks++; if (nb_rdata !== 8'h00) begin errors++; $display("FAIL nb_eof_value: got %h want 00", nb_rdata); end
      checks++; if (nb_rx_level !== 5'd0) begin errors++; $display("FAIL nb_rx_level: got %0d want 0", nb_rx_level); end
      nb_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int bad;
      logic exp_ack;
      do_reset();
      io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h11;
      bad = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         exp_ack = (i % 3) == 1;
         if (io_ack !== exp_ack) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ack_pattern: got %0d wrong cycles want 0", bad); end
      checks++; if (tx_level !== 5'd4) begin errors++; $display("FAIL b2b_push_count: got %0d want 4", tx_level); end
      io_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_wait();
      int lat;
      do_reset();
      for (int i = 0; i < 16; i++) xfer(DIRECTION_WRITE, 8'h20 + 8'(i), lat);
      io_req = 1'b1; io_dir = DIRECTION_WRITE; io_wdata = 8'h66;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL rstwait_ack: got %b want 0", io_ack); end
      checks++; if (tx_level !== 5'd0 || tx_valid !== 1'b0) begin errors++; $display("FAIL rstwait_level: got %0d/%b want 0/0", tx_level, tx_valid); end
      checks++; if (led_n !== 3'b111) begin errors++; $display("FAIL rstwait_led: got %b want 111", led_n); end
      @(negedge clk);
      checks++; if (io_ack !== 1'b1 || tx_level !== 5'd1) begin errors++; $display("FAIL rstwait_new_write: got %b/%0d want 1/1", io_ack, tx_level); end
      checks++; if (led_n !== 3'b001 || tx_data !== 8'h66) begin errors++; $display("FAIL rstwait_new_data: got %b/%h want 001/66", led_n, tx_data); end
      io_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] tx_q[$], rx_q[$];
      logic [7:0] exp_rdata, pend_data;
      logic [2:0] exp_led;
      logic pend, pend_dir, tx_pop_f, rx_push_f;
      do_reset();
      exp_rdata = '0; exp_led = 3'b111; pend = 1'b0; pend_dir = 1'b0; pend_data = '0;
      for (int c = 0; c < 800; c++) begin
         tx_ready = 1'($urandom);
         rx_valid = 1'($urandom);
         rx_data = 8'($urandom);
         tx_pop_f = tx_ready && tx_q.size() > 0;
         rx_push_f = rx_valid && rx_q.size() < 16;
         if (!pend && c < 650 && $urandom_range(0, 2) == 0) begin
            pend = 1'b1; pend_dir = 1'($urandom); pend_data = 8'($urandom);
            io_req = 1'b1; io_dir = pend_dir; io_wdata = pend_data;
         end
         @(negedge clk);
         if (tx_pop_f) void'(tx_q.pop_front());
         if (io_ack) begin
            checks++;
            if (!pend) begin errors++; $display("FAIL rnd_spurious_ack: got 1 want 0 at cycle %0d", c); end
            else if (pend_dir == DIRECTION_WRITE) begin tx_q.push_back(pend_data); exp_led = ~pend_data[2:0]; end
            else if (rx_q.size() == 0) begin errors++; $display("FAIL rnd_read_empty: got ack want stall at cycle %0d", c); end
            else exp_rdata = rx_q.pop_front();
            pend = 1'b0; io_req = 1'b0;
         end
         if (rx_push_f) rx_q.push_back(rx_data);
         checks++; if (tx_level !== 5'(tx_q.size()) || tx_valid !== (tx_q.size() > 0)) begin errors++; $display("FAIL rnd_tx_state: got %0d/%b want %0d at cycle %0d", tx_level, tx_valid, tx_q.size(), c); end
         checks++; if (rx_level !== 5'(rx_q.size()) || rx_ready !== (rx_q.size() < 16)) begin errors++; $display("FAIL rnd_rx_state: got %0d/%b want %0d at cycle %0d", rx_level, rx_ready, rx_q.size(), c); end
         if (tx_q.size() > 0) begin
            checks++; if (tx_data !== tx_q[0]) begin errors++; $display("FAIL rnd_tx_data: got %h want %h at cycle %0d", tx_data, tx_q[0], c); end
         end
         checks++; if (io_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata: got %h want %h at cycle %0d", io_rdata, exp_rdata, c); end
         checks++; if (led_n !== exp_led) begin errors++; $display("FAIL rnd_led: got %b want %b at cycle %0d", led_n, exp_led, c); end
      end
      checks++; if (pend) begin errors++; $display("FAIL rnd_pending: got request outstanding want none"); end
      tx_ready = 1'b0; rx_valid = 1'b0; io_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_tx_full();
      test_blocking_read();
      test_nonblocking_read();
      test_back_to_back();
      test_reset_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
